// File: rtl/mem_stage.sv
// Memory stage of the RV32I pipeline: issues loads/stores over a valid/ready port and registers the writeback bundle.
// Optional misaligned-access trap is enabled by defining MEM_MISALIGN_TRAP_EN.
module mem_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic        ex_RegWrite,
    input  logic [1:0]  ex_ResultSrc,
    input  logic        ex_MemWrite,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_alu_result,
    input  logic [31:0] ex_rd2,
    input  logic [4:0]  ex_rd,
    input  logic [31:0] ex_pc_cur,
    output logic        dmem_req_valid,
    input  logic        dmem_req_ready,
    output logic [31:0] dmem_addr,
    output logic        dmem_we,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_rsp_valid,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic        wb_RegWrite,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_result,
    output logic [31:0] wb_pc_cur,
    output logic        wb_fault
);

    localparam logic [1:0] RESULT_SRC_MEM = 2'b01;
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TO_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t state, state_next;

    logic             r_RegWrite;
    logic             r_is_store;
    logic [2:0]       r_funct3;
    logic [31:0]      r_alu;
    logic [4:0]       r_rd;
    logic [31:0]      r_pc;
    logic [CNT_W-1:0] to_cnt;

    logic        accept;
    logic        ex_is_load;
    logic        ex_is_mem;
    logic        ex_misaligned;
    logic [1:0]  ex_off;
    logic [3:0]  ex_be;
    logic [31:0] ex_wdata;
    logic [1:0]  r_off;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;
    logic        rsp_hit;
    logic        timed_out;

    assign ex_ready   = (state == S_IDLE);
    assign accept     = ex_valid && ex_ready;
    assign ex_is_load = (ex_ResultSrc == RESULT_SRC_MEM) && !ex_MemWrite;
    assign ex_is_mem  = ex_MemWrite || ex_is_load;
    assign ex_off     = ex_alu_result[1:0];
    assign r_off      = r_alu[1:0];
    assign rsp_hit    = (state == S_WAIT) && dmem_rsp_valid;
    // A response on the expiry cycle takes priority over the timeout.
    assign timed_out  = (TIMEOUT_CYCLES > 0) && (state == S_WAIT) && !dmem_rsp_valid
                        && (to_cnt == TO_LAST);

`ifdef MEM_MISALIGN_TRAP_EN
    always_comb begin
        ex_misaligned = 1'b0;
        case (ex_funct3)
            3'b001:  ex_misaligned = ex_is_mem && ex_off[0];
            3'b101:  ex_misaligned = ex_is_load && ex_off[0];
            3'b010:  ex_misaligned = ex_is_mem && (ex_off != 2'b00);
            default: ex_misaligned = 1'b0;
        endcase
    end
`else
    assign ex_misaligned = 1'b0;
`endif

    always_comb begin
        ex_be    = 4'b1111;
        ex_wdata = ex_rd2;
        case (ex_funct3)
            3'b000: begin
                ex_be    = 4'b0001 << ex_off;
                ex_wdata = {4{ex_rd2[7:0]}};
            end
            3'b001: begin
                ex_be    = 4'b0011 << {ex_off[1], 1'b0};
                ex_wdata = {2{ex_rd2[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_byte = dmem_rdata[7:0];
        case (r_off)
            2'd1:    ld_byte = dmem_rdata[15:8];
            2'd2:    ld_byte = dmem_rdata[23:16];
            2'd3:    ld_byte = dmem_rdata[31:24];
            default: ld_byte = dmem_rdata[7:0];
        endcase
        ld_half = r_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (r_funct3)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_data = {24'd0, ld_byte};
            3'b101:  ld_data = {16'd0, ld_half};
            default: ld_data = dmem_rdata;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (accept && ex_is_mem && !ex_misaligned) state_next = S_REQ;
            S_REQ:  if (dmem_req_ready) state_next = r_is_store ? S_IDLE : S_WAIT;
            S_WAIT: if (rsp_hit || timed_out) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Bundle capture, dmem request registers and the one-cycle writeback pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_RegWrite     <= 1'b0;
            r_is_store     <= 1'b0;
            r_funct3       <= 3'd0;
            r_alu          <= 32'd0;
            r_rd           <= 5'd0;
            r_pc           <= 32'd0;
            to_cnt         <= '0;
            dmem_req_valid <= 1'b0;
            dmem_addr      <= 32'd0;
            dmem_we        <= 1'b0;
            dmem_be        <= 4'd0;
            dmem_wdata     <= 32'd0;
            wb_valid       <= 1'b0;
            wb_RegWrite    <= 1'b0;
            wb_rd          <= 5'd0;
            wb_result      <= 32'd0;
            wb_pc_cur      <= 32'd0;
            wb_fault       <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            wb_fault <= 1'b0;
            case (state)
                S_IDLE: if (accept) begin
                    r_RegWrite <= ex_RegWrite;
                    r_is_store <= ex_MemWrite;
                    r_funct3   <= ex_funct3;
                    r_alu      <= ex_alu_result;
                    r_rd       <= ex_rd;
                    r_pc       <= ex_pc_cur;
                    if (ex_is_mem && !ex_misaligned) begin
                        dmem_req_valid <= 1'b1;
                        dmem_addr      <= {ex_alu_result[31:2], 2'b00};
                        dmem_we        <= ex_MemWrite;
                        dmem_be        <= ex_be;
                        dmem_wdata     <= ex_wdata;
                    end else begin
                        wb_valid    <= 1'b1;
                        wb_RegWrite <= ex_RegWrite && !ex_misaligned;
                        wb_rd       <= ex_rd;
                        wb_result   <= ex_alu_result;
                        wb_pc_cur   <= ex_pc_cur;
                        wb_fault    <= ex_misaligned;
                    end
                end
                S_REQ: if (dmem_req_ready) begin
                    dmem_req_valid <= 1'b0;
                    dmem_we        <= 1'b0;
                    dmem_be        <= 4'd0;
                    to_cnt         <= '0;
                    if (r_is_store) begin
                        wb_valid    <= 1'b1;
                        wb_RegWrite <= 1'b0;
                        wb_rd       <= r_rd;
                        wb_result   <= r_alu;
                        wb_pc_cur   <= r_pc;
                    end
                end
                S_WAIT: begin
                    if (rsp_hit) begin
                        wb_valid    <= 1'b1;
                        wb_RegWrite <= r_RegWrite;
                        wb_rd       <= r_rd;
                        wb_result   <= ld_data;
                        wb_pc_cur   <= r_pc;
                    end else if (timed_out) begin
                        wb_valid    <= 1'b1;
                        wb_RegWrite <= 1'b0;
                        wb_rd       <= r_rd;
                        wb_result   <= 32'd0;
                        wb_pc_cur   <= r_pc;
                        wb_fault    <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: directed vectors plus a scoreboard of expected writeback bundles.
// Honours MEM_MISALIGN_TRAP_EN when the design is built with it.
module tb_mem_stage;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid, ex_ready, ex_RegWrite, ex_MemWrite;
    logic [1:0]  ex_ResultSrc;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_alu_result, ex_rd2, ex_pc_cur;
    logic [4:0]  ex_rd;
    logic        dmem_req_valid, dmem_req_ready, dmem_we, dmem_rsp_valid;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        wb_valid, wb_RegWrite, wb_fault;
    logic [4:0]  wb_rd;
    logic [31:0] wb_result, wb_pc_cur;

    always #5 clk = ~clk;

    mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_RegWrite(ex_RegWrite),
        .ex_ResultSrc(ex_ResultSrc), .ex_MemWrite(ex_MemWrite), .ex_funct3(ex_funct3),
        .ex_alu_result(ex_alu_result), .ex_rd2(ex_rd2), .ex_rd(ex_rd), .ex_pc_cur(ex_pc_cur),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
        .dmem_addr(dmem_addr), .dmem_we(dmem_we), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_rsp_valid(dmem_rsp_valid), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_RegWrite(wb_RegWrite), .wb_rd(wb_rd),
        .wb_result(wb_result), .wb_pc_cur(wb_pc_cur), .wb_fault(wb_fault)
    );

    typedef struct {
        logic        rw;
        logic [4:0]  rd;
        logic [31:0] result;
        logic [31:0] pc;
        logic        fault;
        bit          chk_rd;
        bit          chk_res;
    } wb_exp_t;

    wb_exp_t exp_q[$];
    wb_exp_t e;
    int checks = 0;
    int errors = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                               input logic [31:0] word);
        logic [31:0] b, h;
        int sb, sh;
        sb = 8 * int'(addr[1:0]);
        sh = 16 * int'(addr[1]);
        b = (word >> sb) & 32'h0000_00FF;
        h = (word >> sh) & 32'h0000_FFFF;
        case (f3)
            3'b000:  return b[7]  ? (b | 32'hFFFF_FF00) : b;
            3'b001:  return h[15] ? (h | 32'hFFFF_0000) : h;
            3'b100:  return b;
            3'b101:  return h;
            default: return word;
        endcase
    endfunction

    function automatic bit model_misaligned(input logic [2:0] f3, input logic [31:0] addr,
                                            input bit is_store);
        if (f3 == 3'b001 || (f3 == 3'b101 && !is_store)) return addr[0];
        if (f3 == 3'b010) return addr[1:0] != 2'b00;
        return 1'b0;
    endfunction

    // Scoreboard: every wb pulse must match the oldest expectation; pending requests must hold steady.
    logic        prev_pend = 1'b0;
    logic [31:0] p_addr, p_wdata;
    logic [3:0]  p_be;
    logic        p_we;
    always @(negedge clk) begin
        if (reset) begin
            prev_pend = 1'b0;
        end else begin
            if (wb_valid) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_wb", 32'(wb_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("wb_RegWrite", 32'(wb_RegWrite), 32'(e.rw));
                    checkOutput("wb_fault", 32'(wb_fault), 32'(e.fault));
                    checkOutput("wb_pc_cur", wb_pc_cur, e.pc);
                    if (e.chk_rd)  checkOutput("wb_rd", 32'(wb_rd), 32'(e.rd));
                    if (e.chk_res) checkOutput("wb_result", wb_result, e.result);
                end
            end
            if (prev_pend) begin
                checkOutput("hold_valid", 32'(dmem_req_valid), 32'd1);
                checkOutput("hold_addr", dmem_addr, p_addr);
                checkOutput("hold_be", 32'(dmem_be), 32'(p_be));
                checkOutput("hold_we", 32'(dmem_we), 32'(p_we));
                checkOutput("hold_wdata", dmem_wdata, p_wdata);
            end
            prev_pend = dmem_req_valid && !dmem_req_ready;
            p_addr = dmem_addr; p_be = dmem_be; p_we = dmem_we; p_wdata = dmem_wdata;
        end
    end

    task automatic applyStimulus(input logic rw, input logic [1:0] rs, input logic mw,
                                 input logic [2:0] f3, input logic [31:0] alu,
                                 input logic [31:0] rd2, input logic [4:0] rd,
                                 input logic [31:0] pc);
        checkOutput("ex_ready_idle", 32'(ex_ready), 32'd1);
        ex_RegWrite = rw; ex_ResultSrc = rs; ex_MemWrite = mw; ex_funct3 = f3;
        ex_alu_result = alu; ex_rd2 = rd2; ex_rd = rd; ex_pc_cur = pc;
        ex_valid = 1'b1;
        @(posedge clk); #1;
        ex_valid = 1'b0;
    endtask

    task automatic runAlu(input logic [31:0] alu, input logic [4:0] rd, input logic [31:0] pc);
        exp_q.push_back('{1'b1, rd, alu, pc, 1'b0, 1'b1, 1'b1});
        applyStimulus(1'b1, 2'b00, 1'b0, 3'b000, alu, 32'd0, rd, pc);
        checkOutput("alu_latency", 32'(wb_valid), 32'd1);
        checkOutput("alu_no_req", 32'(dmem_req_valid), 32'd0);
    endtask

    // Issues a load/store and plays the memory side; returns when the wb pulse is visible.
    task automatic runMem(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rd2,
                          input bit is_store, input int req_wait, input int rsp_wait,
                          input logic [31:0] rdata, input bit give_rsp, input bit noise,
                          input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                          input logic [4:0] rd, input logic [31:0] pc);
        bit mis;
        mis = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
        mis = model_misaligned(f3, addr, is_store);
`endif
        if (mis)
            exp_q.push_back('{1'b0, rd, addr, pc, 1'b1, 1'b0, 1'b1});
        else if (is_store)
            exp_q.push_back('{1'b0, rd, 32'd0, pc, 1'b0, 1'b0, 1'b0});
        else if (give_rsp)
            exp_q.push_back('{1'b1, rd, model_load(f3, addr, rdata), pc, 1'b0, 1'b1, 1'b1});
        else
            exp_q.push_back('{1'b0, rd, 32'd0, pc, 1'b1, 1'b0, 1'b1});
        applyStimulus(!is_store, is_store ? 2'b00 : 2'b01, is_store, f3, addr, rd2, rd, pc);
        if (mis) begin
            checkOutput("mis_no_req", 32'(dmem_req_valid), 32'd0);
            return;
        end
        checkOutput("req_valid", 32'(dmem_req_valid), 32'd1);
        checkOutput("req_addr", dmem_addr, {addr[31:2], 2'b00});
        checkOutput("req_we", 32'(dmem_we), 32'(is_store));
        if (is_store) begin
            checkOutput("req_be", 32'(dmem_be), 32'(exp_be));
            checkOutput("req_wdata", dmem_wdata, exp_wdata);
        end
        for (int i = 0; i < req_wait; i++) begin
            checkOutput("ex_ready_busy", 32'(ex_ready), 32'd0);
            dmem_rsp_valid = noise;
            dmem_rdata = noise ? 32'hDEAD_BEEF : 32'd0;
            @(posedge clk); #1;
        end
        dmem_rsp_valid = 1'b0;
        dmem_req_ready = 1'b1;
        @(posedge clk); #1;
        dmem_req_ready = 1'b0;
        if (is_store) return;
        if (give_rsp) begin
            for (int i = 0; i < rsp_wait; i++) begin
                @(posedge clk); #1;
                checkOutput("no_early_wb", 32'(wb_valid), 32'd0);
            end
            dmem_rsp_valid = 1'b1;
            dmem_rdata = rdata;
            @(posedge clk); #1;
            dmem_rsp_valid = 1'b0;
        end else begin
            for (int i = 0; i < TO - 1; i++) begin
                @(posedge clk); #1;
                checkOutput("no_early_timeout", 32'(wb_valid), 32'd0);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: actual=still running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1; ex_valid = 1'b0; ex_RegWrite = 1'b0; ex_ResultSrc = 2'b00;
        ex_MemWrite = 1'b0; ex_funct3 = 3'd0; ex_alu_result = 32'd0; ex_rd2 = 32'd0;
        ex_rd = 5'd0; ex_pc_cur = 32'd0; dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0;
        dmem_rdata = 32'd0;
        @(posedge clk); #1;
        checkOutput("rst_ex_ready", 32'(ex_ready), 32'd1);
        checkOutput("rst_wb_valid", 32'(wb_valid), 32'd0);
        checkOutput("rst_wb_result", wb_result, 32'd0);
        checkOutput("rst_wb_fault", 32'(wb_fault), 32'd0);
        checkOutput("rst_req_valid", 32'(dmem_req_valid), 32'd0);
        checkOutput("rst_we", 32'(dmem_we), 32'd0);
        checkOutput("rst_be", 32'(dmem_be), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        runAlu(32'h0000_1234, 5'd5, 32'h0000_0010);
        checkOutput("add_result_lit", wb_result, 32'h0000_1234);
        checkOutput("add_rd_lit", 32'(wb_rd), 32'd5);

        runMem(3'b000, 32'h103, 32'hAABB_CCDD, 1'b1, 3, 0, 32'd0, 1'b1, 1'b0,
               4'b1000, 32'hDDDD_DDDD, 5'd0, 32'h14);
        checkOutput("sb_wb_valid", 32'(wb_valid), 32'd1);
        checkOutput("sb_wb_regwrite", 32'(wb_RegWrite), 32'd0);

        runMem(3'b000, 32'h102, 32'd0, 1'b0, 2, 2, 32'h0080_0000, 1'b1, 1'b1,
               4'd0, 32'd0, 5'd7, 32'h18);
        checkOutput("lb_lit", wb_result, 32'hFFFF_FF80);
        runMem(3'b100, 32'h102, 32'd0, 1'b0, 0, 2, 32'h0080_0000, 1'b1, 1'b0,
               4'd0, 32'd0, 5'd8, 32'h1C);
        checkOutput("lbu_lit", wb_result, 32'h0000_0080);
        runMem(3'b101, 32'h102, 32'd0, 1'b0, 1, 0, 32'h8001_0000, 1'b1, 1'b0,
               4'd0, 32'd0, 5'd9, 32'h20);
        checkOutput("lhu_lit", wb_result, 32'h0000_8001);
        runMem(3'b001, 32'h200, 32'd0, 1'b0, 0, 1, 32'h1234_8123, 1'b1, 1'b0,
               4'd0, 32'd0, 5'd10, 32'h24);
        runMem(3'b010, 32'h300, 32'd0, 1'b0, 0, 0, 32'hCAFE_BABE, 1'b1, 1'b0,
               4'd0, 32'd0, 5'd11, 32'h28);
        runMem(3'b001, 32'h102, 32'h1234_ABCD, 1'b1, 1, 0, 32'd0, 1'b1, 1'b0,
               4'b1100, 32'hABCD_ABCD, 5'd0, 32'h2C);
        runMem(3'b010, 32'h010, 32'h0102_0304, 1'b1, 0, 0, 32'd0, 1'b1, 1'b0,
               4'b1111, 32'h0102_0304, 5'd0, 32'h30);

        runMem(3'b010, 32'h400, 32'd0, 1'b0, 0, 0, 32'd0, 1'b0, 1'b0,
               4'd0, 32'd0, 5'd12, 32'h34);
        checkOutput("to_wb_valid", 32'(wb_valid), 32'd1);
        checkOutput("to_fault_lit", 32'(wb_fault), 32'd1);
        checkOutput("to_regwrite_lit", 32'(wb_RegWrite), 32'd0);
        runMem(3'b010, 32'h404, 32'd0, 1'b0, 0, TO - 1, 32'h55AA_55AA, 1'b1, 1'b0,
               4'd0, 32'd0, 5'd13, 32'h38);
        checkOutput("expiry_rsp_fault", 32'(wb_fault), 32'd0);
        checkOutput("expiry_rsp_result", wb_result, 32'h55AA_55AA);

        runMem(3'b010, 32'h101, 32'd0, 1'b0, 0, 0, 32'h1122_3344, 1'b1, 1'b0,
               4'd0, 32'd0, 5'd14, 32'h3C);
`ifdef MEM_MISALIGN_TRAP_EN
        checkOutput("mis_fault_lit", 32'(wb_fault), 32'd1);
        checkOutput("mis_result_lit", wb_result, 32'h0000_0101);
`else
        checkOutput("mis_as_aligned", wb_result, 32'h1122_3344);
`endif

        runAlu(32'h0000_00AA, 5'd1, 32'h40);
        runAlu(32'h0000_00BB, 5'd2, 32'h44);
        checkOutput("b2b_result", wb_result, 32'h0000_00BB);

        dmem_rsp_valid = 1'b1; dmem_rdata = 32'h1111_1111;
        repeat (2) begin
            @(posedge clk); #1;
            checkOutput("idle_rsp_ignored", 32'(wb_valid), 32'd0);
        end
        dmem_rsp_valid = 1'b0;

        applyStimulus(1'b1, 2'b01, 1'b0, 3'b010, 32'h500, 32'd0, 5'd15, 32'h48);
        dmem_req_ready = 1'b1;
        @(posedge clk); #1;
        dmem_req_ready = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checkOutput("rstmid_ex_ready", 32'(ex_ready), 32'd1);
        checkOutput("rstmid_req_valid", 32'(dmem_req_valid), 32'd0);
        checkOutput("rstmid_be", 32'(dmem_be), 32'd0);
        checkOutput("rstmid_wb_result", wb_result, 32'd0);
        dmem_rsp_valid = 1'b1; dmem_rdata = 32'h2222_2222;
        @(posedge clk); #1;
        dmem_rsp_valid = 1'b0;
        repeat (3) begin
            checkOutput("rstmid_no_wb", 32'(wb_valid), 32'd0);
            @(posedge clk); #1;
        end

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        checkOutput("wb_all_seen", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
